// File: rtl/picorv32_trace_fifo.sv
// picorv32_trace_fifo
//   Capture buffer for the PicoRV32 trace port. The trace stream has no
//   backpressure, so words go into a first-word-fall-through FIFO. If the
//   FIFO is full, incoming words are dropped and counted. As soon as a slot
//   frees up, one marker entry carrying the drop count is inserted.
//
// Ports
//   clk, resetn      clock, asynchronous active-low reset
//   clear            synchronous flush, overrides every push and pop
//   trace_valid/data 36-bit trace word input (cannot be stalled)
//   out_valid/ready  drain handshake: the head is popped on out_valid && out_ready
//   out_data         head payload, forced to 0 while out_valid is 0
//   out_marker       head entry is a drop marker {4'h0, count[31:0]}
//   level            registered occupancy, 0..2^DEPTH_LOG2
//   overflow_sticky  set on the first dropped word, cleared by clear/reset
//   dbg_state_o      current overflow state (0 = NORMAL, 1 = DROP)
//
// Handshake: out_valid depends only on registered state and never looks at
//   out_ready. A transfer happens on every rising edge where both signals are
//   high. The input side has no ready signal.
module picorv32_trace_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  trace_valid,
  input  logic [35:0]           trace_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [35:0]           out_data,
  output logic                  out_marker,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow_sticky,
  output logic                  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DROP   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [31:0]             drop_cnt_q, drop_cnt_d;
  logic                    sticky_q, sticky_d;

  logic [36:0]             mem [DEPTH];

  logic                    full;
  logic                    push;
  logic                    pop;
  logic [36:0]             push_word;
  logic [31:0]             cnt_inc;

  // Fullness comes from the registered level, so a pop in this cycle does
  // not make room for a push in the same cycle.
  assign full    = (level_q == FULL_LVL);
  assign pop     = out_valid && out_ready && !clear;
  assign cnt_inc = (drop_cnt_q == 32'hFFFF_FFFF) ? drop_cnt_q : drop_cnt_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    sticky_d   = sticky_q;
    push       = 1'b0;
    push_word  = '0;
    unique case (state_q)
      ST_NORMAL: begin
        if (trace_valid) begin
          if (!full) begin
            push      = 1'b1;
            push_word = {1'b0, trace_data};
          end else begin
            drop_cnt_d = 32'd1;
            sticky_d   = 1'b1;
            state_d    = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (full) begin
          if (trace_valid) drop_cnt_d = cnt_inc;
        end else begin
          // A word arriving in the marker cycle is lost. It is counted in the
          // marker itself.
          push       = 1'b1;
          push_word  = {1'b1, 4'h0, (trace_valid ? cnt_inc : drop_cnt_q)};
          drop_cnt_d = 32'd0;
          state_d    = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
    if (clear) begin
      push       = 1'b0;
      drop_cnt_d = 32'd0;
      sticky_d   = 1'b0;
      state_d    = ST_NORMAL;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_NORMAL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  // Storage needs no reset: an entry is only visible when level covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  assign out_valid       = (level_q != '0);
  assign out_data        = out_valid ? mem[rd_ptr_q][35:0] : 36'd0;
  assign out_marker      = out_valid ? mem[rd_ptr_q][36]   : 1'b0;
  assign level           = level_q;
  assign overflow_sticky = sticky_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_picorv32_trace_fifo.sv
// Directed testbench for picorv32_trace_fifo with DEPTH_LOG2 = 2 (4 entries).
// Inputs are driven right after a falling edge, and outputs are sampled at the
// following falling edge, which is half a cycle after the active edge.
module tb_picorv32_trace_fifo;

  localparam int DL2 = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clear = 1'b0;
  logic          trace_valid = 1'b0;
  logic [35:0]   trace_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [35:0]   out_data;
  logic          out_marker;
  logic [DL2:0]  level;
  logic          overflow_sticky;
  logic          dbg_state;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [36:0]   exp_q[$];

  picorv32_trace_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .clear           (clear),
    .trace_valid     (trace_valid),
    .trace_data      (trace_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_marker      (out_marker),
    .level           (level),
    .overflow_sticky (overflow_sticky),
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: present inputs for one active edge, then return at the next falling edge
  task automatic step(input logic tv, input logic [35:0] d, input logic rdy);
    trace_valid = tv;
    trace_data  = d;
    out_ready   = rdy;
    @(negedge clk);
    trace_valid = 1'b0;
    trace_data  = '0;
    out_ready   = 1'b0;
  endtask

  // pops every queued expectation and compares it to the head before each pop
  task automatic drain(input string tag);
    logic [36:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_word"}, 64'({out_marker, out_data}), 64'(w));
      step(1'b0, '0, 1'b1);
    end
    check({tag, "_end_level"}, 64'(level), 64'd0);
    check({tag, "_end_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic fill4();
    for (int i = 0; i < 4; i++) step(1'b1, 36'(i), 1'b0);
  endtask

  initial begin
    apply_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_marker", 64'(out_marker), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_sticky", 64'(overflow_sticky), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // single word
    step(1'b1, 36'h9_1234_5678, 1'b0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'h9_1234_5678);
    check("single_marker", 64'(out_marker), 64'd0);
    check("single_level", 64'(level), 64'd1);
    step(1'b0, '0, 1'b1);
    check("single_pop_level", 64'(level), 64'd0);
    check("single_pop_valid", 64'(out_valid), 64'd0);
    check("single_pop_data0", 64'(out_data), 64'd0);

    // wrap-around: push i while popping i-1, so the head is always the newest word
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 36'(i), 1'b1);
      check("wrap_data", 64'(out_data), 64'(i));
      check("wrap_marker", 64'(out_marker), 64'd0);
      check("wrap_level", 64'(level), 64'd1);
    end
    step(1'b0, '0, 1'b1);
    check("wrap_end_level", 64'(level), 64'd0);

    // overflow: 0..3 stored, 4..6 dropped, pop, then word 7 turns into marker count 4
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 36'(i), 1'b0);
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_sticky", 64'(overflow_sticky), 64'd1);
    check("ovf_state", 64'(dbg_state), 64'd1);
    check("ovf_head", 64'(out_data), 64'd0);
    step(1'b0, '0, 1'b1);
    check("ovf_pop_level", 64'(level), 64'd3);
    step(1'b1, 36'd7, 1'b0);
    check("ovf_mark_level", 64'(level), 64'd4);
    check("ovf_mark_state", 64'(dbg_state), 64'd0);
    exp_q.push_back({1'b0, 36'd1});
    exp_q.push_back({1'b0, 36'd2});
    exp_q.push_back({1'b0, 36'd3});
    exp_q.push_back({1'b1, 36'h0_0000_0004});
    drain("ovf_drain");
    check("ovf_sticky_held", 64'(overflow_sticky), 64'd1);

    // full with a simultaneous pop: the pop does not make room for the push
    apply_reset();
    fill4();
    step(1'b1, 36'hA_AAAA_AAAA, 1'b1);
    check("fullpop_level", 64'(level), 64'd3);
    check("fullpop_state", 64'(dbg_state), 64'd1);
    check("fullpop_sticky", 64'(overflow_sticky), 64'd1);
    step(1'b0, '0, 1'b0);
    check("fullpop_mark_level", 64'(level), 64'd4);
    exp_q.push_back({1'b0, 36'd1});
    exp_q.push_back({1'b0, 36'd2});
    exp_q.push_back({1'b0, 36'd3});
    exp_q.push_back({1'b1, 36'h0_0000_0001});
    drain("fullpop_drain");

    // saturation: preload the counter, then drop 5 more words
    apply_reset();
    fill4();
    step(1'b1, 36'd99, 1'b0);
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt_q;
    for (int i = 0; i < 5; i++) step(1'b1, 36'(100 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    exp_q.push_back({1'b0, 36'd1});
    exp_q.push_back({1'b0, 36'd2});
    exp_q.push_back({1'b0, 36'd3});
    exp_q.push_back({1'b1, 36'h0_FFFF_FFFF});
    drain("sat_drain");

    // clear while in DROP with trace_valid high
    apply_reset();
    fill4();
    step(1'b1, 36'd55, 1'b1);
    check("clr_pre_state", 64'(dbg_state), 64'd1);
    clear = 1'b1;
    step(1'b1, 36'd56, 1'b1);
    clear = 1'b0;
    check("clr_level", 64'(level), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_sticky", 64'(overflow_sticky), 64'd0);
    check("clr_state", 64'(dbg_state), 64'd0);
    check("clr_data", 64'(out_data), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check("clr_no_marker", 64'(out_valid), 64'd0);

    // asynchronous reset in the middle of a cycle
    fill4();
    step(1'b1, 36'd77, 1'b0);
    check("arst_pre_level", 64'(level), 64'd4);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_marker", 64'(out_marker), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_sticky", 64'(overflow_sticky), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check("arst_no_marker", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case something stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/picorv32_trace_fifo.md
# picorv32_trace_fifo

Trace capture buffer sitting directly downstream of the PicoRV32 core's trace port in the simulation wrapper. It absorbs the 36-bit `trace_valid`/`trace_data` stream, which has no backpressure, into a first-word-fall-through FIFO and presents it on a valid/ready drain port for a trace dumper or checker. When the FIFO overflows, trace words are counted rather than silently lost. A single marker word carrying the drop count is inserted as soon as space returns.

## Interface
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 entries; legal range 2–10.
- `clk`  in  1  single clock, all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush; highest priority
- `trace_valid`  in  1  trace word present this cycle; no ready, cannot be stalled
- `trace_data`  in  36  trace word from core
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  36  head entry payload
- `out_marker`  out  1  head entry is a drop marker
- `level`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
- `overflow_sticky`  out  1  set on first dropped word, held until `clear` or reset

## Operation
- Storage entry is 37 bits: {marker, data[35:0]}. Circular buffer with read/write pointers of DEPTH_LOG2 bits, wrapping modulo depth.
- `full` means registered `level` == 2^DEPTH_LOG2. A pop in the same cycle does not free a slot for that cycle's push.
- Pop occurs when `out_valid && out_ready`.
- State machine, NORMAL / DROP:
  - NORMAL, `trace_valid`, not full: push {0, trace_data}.
  - NORMAL, `trace_valid`, full: word is lost. `drop_cnt` ← 1, `overflow_sticky` ← 1, go to DROP.
  - DROP, full: each `trace_valid` increments `drop_cnt`, saturating at 32'hFFFF_FFFF.
  - DROP, not full: push marker {1, 4'h0, drop_cnt + trace_valid} (saturating), then go to NORMAL. A `trace_valid` word arriving in the marker cycle is dropped and included in the count.
- After a marker, normal pushes resume on the next cycle. At most one marker exists per overflow episode.
- `level` next value = level + push − pop. Simultaneous push and pop leave it unchanged.
- `clear`: pointers, `level`, `drop_cnt` and `overflow_sticky` go to 0 and state goes to NORMAL. Any push or pop in the same cycle is ignored.
- `out_data` and `out_marker` are forced to 0 while `out_valid` is 0.
- Reset values: `out_valid` 0, `out_data` 0, `out_marker` 0, `level` 0, `overflow_sticky` 0, state NORMAL, `drop_cnt` 0.
- Reset asserted mid-operation discards all contents immediately, asynchronously. No marker is emitted for words lost to reset.

## Timing
- Push at edge N: `out_valid` high and the word on `out_data` from after edge N, i.e. 1-cycle latency, first-word-fall-through.
- Pop at edge N: next entry, or `out_valid` low, visible after edge N.
- `out_valid`, `out_data`, `out_marker` are functions of registered state only; no combinational path from `out_ready` or `trace_*` to outputs.
- `level` and `overflow_sticky` are registered and update at the same edge as the push/pop/drop that causes them.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Single word: reset, push 36'h9_1234_5678 with `out_ready`=0. Required: `out_valid`=1 next cycle, `out_data`=36'h9_1234_5678, `out_marker`=0, `level`=1. Raise `out_ready`: `level`=0 and `out_valid`=0 after that edge.
- Wrap-around: DEPTH_LOG2=2. Stream 20 consecutive words 0..19 with `out_ready`=1 throughout. Required: output order 0..19 exactly, no marker, `level` never exceeds 1.
- Overflow: DEPTH_LOG2=2, `out_ready`=0. Push 7 words 0..6. Required: entries 0..3 stored, `overflow_sticky`=1, `level`=4. Then pop one word and push word 7 in the next cycle. Required: drain order 1,2,3, then marker with `out_data`=36'h0_0000_0004.
- Full with simultaneous pop: FIFO full, `out_ready`=1 and `trace_valid`=1 in the same cycle. Required: word dropped, state DROP, `level`=3. The next cycle inserts a marker with count ≥1.
- Saturation: force `drop_cnt` near 32'hFFFF_FFFE and drop 5 more words. Required: marker data[31:0]=32'hFFFF_FFFF.
- Clear / reset mid-stream: FIFO half full, in DROP. `clear`=1 with `trace_valid`=1. Required: `level`=0, `out_valid`=0, `overflow_sticky`=0, no marker afterward. Repeat with async `resetn` low mid-cycle: outputs 0 immediately, before the next edge.
